// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage request, multiplier/divider drive and HI/LO result bundle for muldiv_ctrl
interface muldiv_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        stallreq;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_annul;
  logic        div_ready;
  logic [63:0] div_result;
  logic        result_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  modport slave (
    input  req_valid, req_op, src1, src2, flush, mul_result, div_ready, div_result,
    output stallreq, mul_signed, mul_a, mul_b, div_start, div_signed, div_op1, div_op2,
           div_annul, result_valid, hi_o, lo_o
  );
  modport master (
    output req_valid, req_op, src1, src2, flush, mul_result, div_ready, div_result,
    input  stallreq, mul_signed, mul_a, mul_b, div_start, div_signed, div_op1, div_op2,
           div_annul, result_valid, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences mult/multu/div/divu through external multiplier/divider and registers HI/LO.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero bypasses the divider (hi=src1, lo=all ones).
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic        w_accept, w_cap, w_div0, w_mul, w_div;
  logic [63:0] w_res;
`ifdef MULDIV_DIV0_FAST_EN
  assign w_div0 = bus.req_op[1] && bus.src2 == '0;
`else
  assign w_div0 = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_cap    = 1'b0;
    w_res    = {r_hi, r_lo};
    case (r_state)
      IDLE: begin
        w_accept = bus.req_valid && !bus.flush;
        if (w_accept) w_next = w_div0 ? DONE : bus.req_op[1] ? DIV : MUL;
        w_cap = w_accept && w_div0;
        w_res = {bus.src1, 32'hFFFF_FFFF};
      end
      MUL: begin
        w_next = bus.flush ? IDLE : r_cnt == '0 ? DONE : MUL;
        w_cap  = !bus.flush && r_cnt == '0;
        w_res  = bus.mul_result;
      end
      DIV: begin
        w_next = bus.flush ? IDLE : bus.div_ready ? DONE : DIV;
        w_cap  = !bus.flush && bus.div_ready;
        w_res  = bus.div_result;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.req_op;
        r_a   <= bus.src1;
        r_b   <= bus.src2;
        r_cnt <= 3'(MUL_LAT - 1);
      end else if (r_state == MUL && r_cnt != '0) r_cnt <= r_cnt - 3'd1;
      if (w_cap) {r_hi, r_lo} <= w_res;
    end
  // Drive outputs are gated by rst so they drop combinationally, not just at the next edge.
  assign w_mul            = !rst && r_state == MUL;
  assign w_div            = !rst && r_state == DIV;
  assign bus.stallreq     = !rst && (r_state == MUL || r_state == DIV ||
                            (r_state == IDLE && bus.req_valid && !bus.flush));
  assign bus.mul_signed   = w_mul && r_op == 2'b00;
  assign bus.mul_a        = w_mul ? r_a : '0;
  assign bus.mul_b        = w_mul ? r_b : '0;
  assign bus.div_start    = w_div && !bus.div_ready;
  assign bus.div_signed   = w_div && r_op == 2'b10;
  assign bus.div_op1      = w_div ? r_a : '0;
  assign bus.div_op2      = w_div ? r_b : '0;
  assign bus.div_annul    = w_div && bus.flush;
  assign bus.result_valid = r_state == DONE;
  assign bus.hi_o         = r_hi;
  assign bus.lo_o         = r_lo;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed tests for muldiv_ctrl with a combinational multiplier and a fixed-latency divider model.
module tb_muldiv_ctrl;
  logic        clk, rst;
  int          ntests, nfail, div_lat;
  logic [63:0] div_res;
  logic [7:0]  dcnt;
  muldiv_ctrl_if bus();
  muldiv_ctrl #(.MUL_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus.mul_result = {{32{bus.mul_signed & bus.mul_a[31]}}, bus.mul_a} *
                          {{32{bus.mul_signed & bus.mul_b[31]}}, bus.mul_b};
  always_ff @(posedge clk or posedge rst)
    if (rst) dcnt <= '0;
    else dcnt <= bus.div_start ? dcnt + 8'd1 : 8'd0;
  assign bus.div_ready  = dcnt != 0 && dcnt == 8'(div_lat);
  assign bus.div_result = div_res;
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int maxc, output int n_stall, output int n_ds, output int n_cyc,
                       output bit got, output bit msig, output logic [31:0] hi, output logic [31:0] lo);
    n_stall = 0; n_ds = 0; n_cyc = -1; got = 0; msig = 0; hi = '0; lo = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.src1 = a; bus.src2 = b;
    for (int i = 0; i < maxc && !got; i++) begin
      #1;
      if (bus.stallreq) n_stall++;
      if (bus.div_start) n_ds++;
      if (bus.mul_signed) msig = 1'b1;
      if (bus.result_valid) begin
        got = 1'b1; n_cyc = i; hi = bus.hi_o; lo = bus.lo_o;
      end else @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.src1 = 32'h55; bus.src2 = 32'h66;
    repeat (2) @(negedge clk);
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0 || bus.result_valid !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0 ||
        bus.div_start !== 1'b0 || bus.mul_a !== 32'h0) begin
      nfail++;
      $display("FAIL reset_state: stall=%b rv=%b hi=%h lo=%h ds=%b mula=%h want all 0",
               bus.stallreq, bus.result_valid, bus.hi_o, bus.lo_o, bus.div_start, bus.mul_a);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; rst = 1'b0;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0 || bus.div_op1 !== 32'h0 || bus.mul_b !== 32'h0) begin
      nfail++;
      $display("FAIL idle_outputs: stall=%b dop1=%h mulb=%h want 0", bus.stallreq, bus.div_op1, bus.mul_b);
    end
  endtask
  task automatic test_multu;
    int ns, nd, nc; bit got, ms; logic [31:0] hi, lo;
    issue(2'b01, 32'hFFFF_FFFF, 32'h2, 20, ns, nd, nc, got, ms, hi, lo);
    ntests++;
    if (!got || ns != 3 || nc != 3 || ms) begin
      nfail++;
      $display("FAIL multu_timing: got=%b stall=%0d cyc=%0d msig=%b want 1 3 3 0", got, ns, nc, ms);
    end
    ntests++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      nfail++;
      $display("FAIL multu_result: hi=%h lo=%h want 00000001 fffffffe", hi, lo);
    end
    @(negedge clk); #1;
    ntests++;
    if (bus.result_valid !== 1'b0) begin
      nfail++;
      $display("FAIL multu_done_len: result_valid=%b want 0", bus.result_valid);
    end
  endtask
  task automatic test_mult;
    int ns, nd, nc; bit got, ms; logic [31:0] hi, lo;
    issue(2'b00, 32'hFFFF_FFFF, 32'h3, 20, ns, nd, nc, got, ms, hi, lo);
    ntests++;
    if (!got || !ms || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL mult_signed: got=%b msig=%b hi=%h lo=%h want 1 1 ffffffff fffffffd", got, ms, hi, lo);
    end
  endtask
  task automatic test_div;
    int ns, nd, nc; bit got, ms; logic [31:0] hi, lo;
    div_lat = 33; div_res = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    issue(2'b10, 32'hFFFF_FFF9, 32'h2, 60, ns, nd, nc, got, ms, hi, lo);
    ntests++;
    if (!got || nd != 33 || ns != 35 || nc != 35) begin
      nfail++;
      $display("FAIL div_timing: got=%b dstart=%0d stall=%0d cyc=%0d want 1 33 35 35", got, nd, ns, nc);
    end
    ntests++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL div_result: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    @(negedge clk); #1;
    ntests++;
    if (bus.result_valid !== 1'b0) begin
      nfail++;
      $display("FAIL div_done_len: result_valid=%b want 0", bus.result_valid);
    end
  endtask
  task automatic test_flush_div;
    bit seen;
    div_lat = 33;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b11; bus.src1 = 32'd100; bus.src2 = 32'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    ntests++;
    if (bus.div_annul !== 1'b0 || bus.div_start !== 1'b1 || bus.div_signed !== 1'b0 || bus.div_op2 !== 32'd7) begin
      nfail++;
      $display("FAIL divu_inflight: annul=%b start=%b sgn=%b op2=%h want 0 1 0 7",
               bus.div_annul, bus.div_start, bus.div_signed, bus.div_op2);
    end
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    ntests++;
    if (bus.div_annul !== 1'b1) begin
      nfail++;
      $display("FAIL div_annul: annul=%b want 1", bus.div_annul);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0 || bus.div_start !== 1'b0 || bus.div_annul !== 1'b0) begin
      nfail++;
      $display("FAIL div_flush_idle: stall=%b start=%b annul=%b want 0 0 0", bus.stallreq, bus.div_start, bus.div_annul);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.result_valid) seen = 1;
    end
    ntests++;
    if (seen || bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL div_flush_noresult: seen_rv=%b hi=%h lo=%h want 0 ffffffff fffffffd", seen, bus.hi_o, bus.lo_o);
    end
  endtask
  task automatic test_flush_mul;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.src1 = 32'd5; bus.src2 = 32'd6;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b1 || bus.mul_a !== 32'd5 || bus.mul_b !== 32'd6) begin
      nfail++;
      $display("FAIL mul_last_cycle: stall=%b a=%h b=%h want 1 5 6", bus.stallreq, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    ntests++;
    if (bus.result_valid !== 1'b0 || bus.stallreq !== 1'b0 || bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL mul_flush_wins: rv=%b stall=%b hi=%h lo=%h want 0 0 ffffffff fffffffd",
               bus.result_valid, bus.stallreq, bus.hi_o, bus.lo_o);
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0) begin
      nfail++;
      $display("FAIL idle_flush_stall: stall=%b want 0", bus.stallreq);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0 || bus.mul_a !== 32'h0) begin
      nfail++;
      $display("FAIL idle_flush_reject: stall=%b mula=%h want 0 0", bus.stallreq, bus.mul_a);
    end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.src1 = 32'd7; bus.src2 = 32'd9;
    repeat (3) @(negedge clk);
    #1;
    ntests++;
    if (bus.result_valid !== 1'b1 || bus.stallreq !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'd63) begin
      nfail++;
      $display("FAIL b2b_first: rv=%b stall=%b hi=%h lo=%h want 1 0 0 3f",
               bus.result_valid, bus.stallreq, bus.hi_o, bus.lo_o);
    end
    bus.req_op = 2'b00; bus.src1 = 32'hFFFF_FFFF; bus.src2 = 32'h3;
    @(negedge clk); #1;
    ntests++;
    if (bus.stallreq !== 1'b1 || bus.result_valid !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_accept: stall=%b rv=%b want 1 0", bus.stallreq, bus.result_valid);
    end
    repeat (3) @(negedge clk);
    #1;
    ntests++;
    if (bus.result_valid !== 1'b1 || bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFFD) begin
      nfail++;
      $display("FAIL b2b_second: rv=%b hi=%h lo=%h want 1 ffffffff fffffffd", bus.result_valid, bus.hi_o, bus.lo_o);
    end
    bus.req_valid = 1'b0;
  endtask
  task automatic test_reset_mid_div;
    bit bad;
    div_lat = 33;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.src1 = 32'd50; bus.src2 = 32'd5;
    repeat (5) @(negedge clk);
    #1;
    ntests++;
    if (bus.div_start !== 1'b1 || bus.div_signed !== 1'b1 || bus.stallreq !== 1'b1) begin
      nfail++;
      $display("FAIL div_signed_run: start=%b sgn=%b stall=%b want 1 1 1", bus.div_start, bus.div_signed, bus.stallreq);
    end
    #1 rst = 1'b1;
    #1;
    ntests++;
    if (bus.stallreq !== 1'b0 || bus.div_start !== 1'b0 || bus.div_signed !== 1'b0 ||
        bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      nfail++;
      $display("FAIL reset_mid_div: stall=%b start=%b sgn=%b hi=%h lo=%h want 0 0 0 0 0",
               bus.stallreq, bus.div_start, bus.div_signed, bus.hi_o, bus.lo_o);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (bus.result_valid || bus.stallreq) bad = 1;
    end
    ntests++;
    if (bad) begin
      nfail++;
      $display("FAIL reset_abandon: result_valid or stallreq seen=%b want 0", bad);
    end
  endtask
  task automatic test_div0;
    int ns, nd, nc; bit got, ms; logic [31:0] hi, lo;
    div_lat = 3; div_res = {32'h0000_1234, 32'hFFFF_FFFF};
    issue(2'b11, 32'h1234, 32'h0, 20, ns, nd, nc, got, ms, hi, lo);
`ifdef MULDIV_DIV0_FAST_EN
    ntests++;
    if (!got || nc != 1 || nd != 0 || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL div0_fast: got=%b cyc=%0d dstart=%0d hi=%h lo=%h want 1 1 0 1234 ffffffff", got, nc, nd, hi, lo);
    end
`else
    ntests++;
    if (!got || nd != 3 || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL div0_divider: got=%b dstart=%0d hi=%h lo=%h want 1 3 1234 ffffffff", got, nd, hi, lo);
    end
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    ntests = 0; nfail = 0; div_lat = 33; div_res = '0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_flush_div();
    test_flush_mul();
    test_back_to_back();
    test_reset_mid_div();
    test_div0();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LAT, default 2, multiplier latency in cycles from operand presentation to valid mul_result (legal 1..7).
REQ-002 SHALL have ports: clk  in  1  clock, all state updates on posedge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid  in  1  EX stage holds a mult/multu/div/divu instruction.
REQ-005 SHALL have ports: req_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have ports: src1, src2  in  32 each  rs and rt operands.
REQ-007 SHALL have ports: flush  in  1  discard the in-flight operation.
REQ-008 SHALL have ports: stallreq  out  1  request to freeze the pipeline at EX.
REQ-009 SHALL have ports: mul_signed  out  1; mul_a, mul_b  out  32 each; mul_result  in  64.
REQ-010 SHALL have ports: div_start  out  1; div_signed  out  1; div_op1, div_op2  out  32 each; div_annul  out  1; div_ready  in  1; div_result  in  64 ({remainder, quotient}).
REQ-011 SHALL have ports: result_valid  out  1; hi_o, lo_o  out  32 each  registered HI/LO write data.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-013 IDLE: when req_valid=1 and flush=0, latch req_op, src1, src2; go to MUL (op 0x) with cnt=MUL_LAT-1, or to DIV (op 1x); otherwise stay in IDLE.
REQ-014 stallreq SHALL be combinational: 1 in IDLE when req_valid=1 and flush=0, 1 in MUL and DIV, 0 in DONE and otherwise.
REQ-015 MUL: mul_a/mul_b driven from latched operands and mul_signed=(op==00) on every MUL cycle; cnt decrements each cycle; when cnt==0, capture hi_o=mul_result[63:32], lo_o=mul_result[31:0] and go to DONE.
REQ-016 Multiply latency SHALL therefore be MUL_LAT+1 cycles from acceptance to result_valid.
REQ-017 DIV: div_start=1, div_signed=(op==10), div_op1/div_op2 from latched operands every cycle until div_ready=1; on div_ready=1 capture hi_o=div_result[63:32], lo_o=div_result[31:0] and go to DONE; div_start=0 in the div_ready cycle.
REQ-018 DONE lasts exactly one cycle: result_valid=1, stallreq=0, req_valid ignored; next state IDLE.
REQ-019 Outside MUL/DIV, mul_*, div_start, div_signed, div_op1/div_op2 SHALL be 0.
REQ-020 flush in any state SHALL force IDLE next cycle without result_valid; hi_o/lo_o unchanged.
REQ-021 flush in DIV SHALL assert div_annul=1 that same cycle; div_annul=0 otherwise.
REQ-022 flush and div_ready (or MUL cnt==0) in the same cycle: flush wins, no capture.
REQ-023 Back-to-back requests: a request present in the cycle after DONE SHALL be accepted as new.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, cnt=0, latched operands=0, hi_o=lo_o=0, result_valid=0; stallreq=0 and all divider/multiplier drive outputs 0 while rst=1.
REQ-025 rst asserted mid-MUL or mid-DIV SHALL abandon the operation; no result_valid after release.

Configuration
REQ-026 Macro MULDIV_DIV0_FAST_EN: when defined, a div/divu accepted with src2==0 SHALL bypass the divider (div_start never asserted), go directly to DONE next cycle with hi_o=src1, lo_o=32'hFFFFFFFF; when undefined, such requests enter DIV and are handled by the divider as any other.

Verification
REQ-027 MUL_LAT=2, multu 0xFFFFFFFF*0x2 -> stallreq high 3 cycles, result_valid next cycle, hi_o=0x00000001, lo_o=0xFFFFFFFE.
REQ-028 mult 0xFFFFFFFF*0x3 (signed) -> mul_signed=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
REQ-029 div 0xFFFFFFF9/0x2, model div_ready after 33 cycles returning {0xFFFFFFFF,0xFFFFFFFD} -> div_start high until ready, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD, result_valid one cycle.
REQ-030 divu in flight, flush asserted cycle 10 -> div_annul=1 that cycle, IDLE next cycle, no result_valid, hi_o/lo_o unchanged.
REQ-031 rst asserted mid-DIV between clock edges -> stallreq and div_start drop immediately, hi_o=lo_o=0.
REQ-032 With MULDIV_DIV0_FAST_EN, divu 0x1234/0 -> result_valid 2nd cycle, hi_o=0x00001234, lo_o=0xFFFFFFFF, div_start never 1; without macro, div_start asserted.
